// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data memory access (byte/half/word loads and stores with
// sign/zero extension, optional wait states with upstream stall) followed by
// the MEM/WB pipeline register.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- when defined, misaligned
// accesses are flagged on MisalignW instead of being silently aligned.
module mem_wb_stage #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic        ResultSrcM,
   input  logic [2:0]  funct3M,
   input  logic [4:0]  RD_M,
   input  logic [31:0] PCPlus4M,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] ALU_ResultM,
   output logic        StallM,
   output logic        RegWriteW,
   output logic        ResultSrcW,
   output logic [4:0]  RD_W,
   output logic [31:0] PCPlus4W,
   output logic [31:0] ALU_ResultW,
   output logic [31:0] ReadDataW,
   output logic        MisalignW
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = 3;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   mem_q [DEPTH];

   logic          access, mem_acc, misalign, done;
   logic          is_byte, is_half, is_unsigned;
   logic [1:0]    off;
   logic [AW-1:0] idx;
   logic [31:0]   rd_word, shifted, load_ext, wdata;
   logic [3:0]    be;

   logic          reg_write_q, result_src_q, misalign_q;
   logic [4:0]    rd_q;
   logic [31:0]   pc_plus4_q, alu_result_q, read_data_q;

   assign access  = MemReadM | MemWriteM;
   assign idx     = ALU_ResultM[AW+1:2];
   assign rd_word = mem_q[idx];

   // Access size and signedness from funct3; unknown codes behave as word
   always_comb begin
      is_byte     = 1'b0;
      is_half     = 1'b0;
      is_unsigned = 1'b0;
      case (funct3M)
         3'b000:  is_byte = 1'b1;
         3'b001:  is_half = 1'b1;
         3'b100: begin
            is_byte     = 1'b1;
            is_unsigned = 1'b1;
         end
         3'b101: begin
            is_half     = 1'b1;
            is_unsigned = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign = access & ((is_half & ALU_ResultM[0]) |
                               (!is_byte & !is_half & (ALU_ResultM[1:0] != 2'b00)));
   assign off      = ALU_ResultM[1:0];
`else
   assign misalign = 1'b0;
   assign off      = is_byte ? ALU_ResultM[1:0] :
                     is_half ? {ALU_ResultM[1], 1'b0} : 2'b00;
`endif

   // Misaligned accesses never touch memory and never wait
   assign mem_acc = access & !misalign;

   // Lane select and extension of the loaded data
   assign shifted = rd_word >> {off, 3'b000};
   always_comb begin
      load_ext = rd_word;
      if (is_byte)
         load_ext = is_unsigned ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      else if (is_half)
         load_ext = is_unsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
   end

   // Store byte enables and lane-replicated write data
   always_comb begin
      be    = 4'b1111;
      wdata = WriteDataM;
      if (is_byte) begin
         be    = 4'b0001 << off;
         wdata = {4{WriteDataM[7:0]}};
      end else if (is_half) begin
         be    = 4'b0011 << off;
         wdata = {2{WriteDataM[15:0]}};
      end
   end

   // Wait-state FSM: next state, counter and stall request
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done    = 1'b1;
      StallM  = 1'b0;
      if (WAIT_CYCLES != 0) begin
         done = 1'b0;
         case (state_q)
            IDLE: begin
               if (mem_acc) begin
                  state_d = BUSY;
                  cnt_d   = CW'(WAIT_CYCLES - 1);
               end
            end
            BUSY: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CW'(1);
               end else begin
                  state_d = IDLE;
                  done    = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
         StallM = mem_acc & !done;
      end
   end

   // FSM state register; reset aborts any pending access
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Data memory write, only on the completing edge of a store
   always_ff @(posedge clk) begin
      if (MemWriteM && !misalign && done) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // MEM/WB register: bubble while stalled, otherwise capture the M stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_write_q  <= 1'b0;
         result_src_q <= 1'b0;
         misalign_q   <= 1'b0;
         rd_q         <= '0;
         pc_plus4_q   <= '0;
         alu_result_q <= '0;
         read_data_q  <= '0;
      end else if (StallM) begin
         reg_write_q <= 1'b0;
         misalign_q  <= 1'b0;
      end else begin
         reg_write_q  <= RegWriteM & !misalign;
         result_src_q <= ResultSrcM;
         misalign_q   <= misalign;
         rd_q         <= RD_M;
         pc_plus4_q   <= PCPlus4M;
         alu_result_q <= ALU_ResultM;
         read_data_q  <= load_ext;
      end
   end

   assign RegWriteW   = reg_write_q;
   assign ResultSrcW  = result_src_q;
   assign MisalignW   = misalign_q;
   assign RD_W        = rd_q;
   assign PCPlus4W    = pc_plus4_q;
   assign ALU_ResultW = alu_result_q;
   assign ReadDataW   = read_data_q;

   // Address bits above the array and unused high load lanes
   logic unused;
   assign unused = ^{shifted[31:16], ALU_ResultM[31:AW+2]};
endmodule
